pkt_spi_read: RTL

Packet-FIFO-to-SPI read bridge: drains packets from a show-ahead packet FIFO and returns them byte-by-byte on the SPI "simple bus" read path. Each read transaction first returns a status byte and then the bytes of the packet currently at the FIFO head, stopping cleanly at the packet boundary. It sits between the SPI slave core and the downstream packet FIFO. It is the host-facing counterpart of the SPI packet write path.

---
 rtl/pkt_spi_read_pkg.sv | 28 ++
 rtl/pkt_spi_read_if.sv | 26 ++
 rtl/pkt_spi_read_rgb_pack565.sv | 42 ++++
 rtl/pkt_spi_read.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_spi_read_pkg.sv
// Shared definitions for the packet-FIFO-to-SPI read bridge: state encoding,
// status byte layout and the pad byte returned when there is nothing to read.
package pkt_spi_read_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_STAT = 3'd1;
   localparam state_t ST_RAW  = 3'd2;
   localparam state_t ST_PK_R = 3'd3;
   localparam state_t ST_PK_G = 3'd4;
   localparam state_t ST_PK_B = 3'd5;
   localparam state_t ST_EOP  = 3'd6;

   localparam int STAT_NEMPTY_BIT   = 7;
   localparam int STAT_UNDERRUN_BIT = 6;

   localparam logic [7:0] PAD_BYTE = 8'h00;

   function automatic logic [7:0] status_byte(input logic nempty, input logic underrun);
      logic [7:0] s;
      s                    = PAD_BYTE;
      s[STAT_NEMPTY_BIT]   = nempty;
      s[STAT_UNDERRUN_BIT] = underrun;
      return s;
   endfunction

endpackage

// File: rtl/pkt_spi_read_if.sv
// Simple-bus read path plus show-ahead packet FIFO head, bundled together.
// master: SPI core / FIFO side.  slave: the read bridge.
interface pkt_spi_read_if;
   logic [7:0] sb_addr;
   logic       sb_first;
   logic       sb_strobe;
   logic [7:0] sb_rdata;
   logic [7:0] fifo_data;
   logic       fifo_last;
   logic       fifo_empty;
   logic       fifo_rden;

   modport master (
      output sb_addr, sb_first, sb_strobe,
      input  sb_rdata,
      output fifo_data, fifo_last, fifo_empty,
      input  fifo_rden
   );

   modport slave (
      input  sb_addr, sb_first, sb_strobe,
      output sb_rdata,
      input  fifo_data, fifo_last, fifo_empty,
      output fifo_rden
   );
endinterface

// File: rtl/pkt_spi_read_rgb_pack565.sv
// RGB888 -> RGB565 byte packer: holds the captured R and G component bits
// and forms the two output bytes. Only instantiated when
// PKT_SPI_READ_PACK_EN is defined. Only the bits that reach an output byte
// are stored.
module rgb_pack565 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cap_r,
   input  logic       cap_g,
   input  logic [4:0] r_hi,    // R[7:3]
   input  logic [2:0] g_hi,    // G[7:5]
   input  logic [2:0] g_mid,   // G[4:2]
   input  logic [4:0] b_hi,    // B[7:3]
   output logic [7:0] rg_byte,
   output logic [7:0] gb_byte
);

   logic [4:0] r_q, r_d;
   logic [2:0] g_q, g_d;

   // capture the popped component when the controller asks for it
   always_comb begin
      r_d = cap_r ? r_hi  : r_q;
      g_d = cap_g ? g_mid : g_q;
   end

   // component registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= 5'd0;
         g_q <= 3'd0;
      end else begin
         r_q <= r_d;
         g_q <= g_d;
      end
   end

   // first byte takes G straight from the FIFO head in the G pop cycle
   assign rg_byte = {r_q, g_hi};
   assign gb_byte = {g_q, b_hi};

endmodule

// File: rtl/pkt_spi_read.sv
// Packet-FIFO-to-SPI read bridge. A read transaction returns a status byte
// {~fifo_empty, underrun, 6'b0} followed by the bytes of the head packet,
// then pad bytes once the packet boundary is reached.
// Optional feature: PKT_SPI_READ_PACK_EN enables packed RGB888->RGB565 reads
// at BASE|1; without it BASE|1 is an alias of the raw address.
//
// state | meaning
// IDLE  | no transaction for us; data strobes return pad
// STAT  | status byte loaded, waiting for the strobe that shifts it out
// RAW   | raw packet bytes, one pop per data strobe
// PK_R  | packed: next data strobe pops R
// PK_G  | packed: pop G and load {R[7:3],G[7:5]} (no strobe needed)
// PK_B  | packed: next data strobe pops B and loads {G[4:2],B[7:3]}
// EOP   | packet finished; pad until the next command byte
module pkt_spi_read
   import pkt_spi_read_pkg::*;
#(
   parameter logic [7:0] BASE = 8'h20
) (
   input  logic           clk,
   input  logic           rst_n,
   pkt_spi_read_if.slave  bus
);

   state_t     state_q, state_d;
   logic [7:0] sb_rdata_q, sb_rdata_d;
   logic       underrun_q, underrun_d;
   logic       pop;
   logic       fetch_raw;
   logic       cmd, dat, hit;

   assign cmd = bus.sb_strobe &  bus.sb_first;
   assign dat = bus.sb_strobe & ~bus.sb_first;
   assign hit = (bus.sb_addr[7:1] == BASE[7:1]);

`ifdef PKT_SPI_READ_PACK_EN
   logic       packed_q, packed_d;
   logic       pad_b_q, pad_b_d;
   logic       fetch_r, fetch_g, fetch_b;
   logic       cap_r, cap_g;
   logic [2:0] g_hi, g_mid;
   logic [4:0] b_hi;
   logic [7:0] rg_byte, gb_byte;

   // missing components (empty FIFO or packet ended early) read as zero
   assign g_hi  = bus.fifo_empty ? 3'd0 : bus.fifo_data[7:5];
   assign g_mid = bus.fifo_empty ? 3'd0 : bus.fifo_data[4:2];
   assign b_hi  = (bus.fifo_empty | pad_b_q) ? 5'd0 : bus.fifo_data[7:3];

   rgb_pack565 u_pack (
      .clk     (clk),
      .rst_n   (rst_n),
      .cap_r   (cap_r),
      .cap_g   (cap_g),
      .r_hi    (bus.fifo_data[7:3]),
      .g_hi    (g_hi),
      .g_mid   (g_mid),
      .b_hi    (b_hi),
      .rg_byte (rg_byte),
      .gb_byte (gb_byte)
   );
`endif

   // next-state, output byte, pop and underrun decisions
   always_comb begin
      state_d    = state_q;
      sb_rdata_d = sb_rdata_q;
      underrun_d = underrun_q;
      pop        = 1'b0;
      fetch_raw  = 1'b0;
`ifdef PKT_SPI_READ_PACK_EN
      packed_d   = packed_q;
      pad_b_d    = pad_b_q;
      fetch_r    = 1'b0;
      fetch_g    = 1'b0;
      fetch_b    = 1'b0;
      cap_r      = 1'b0;
      cap_g      = 1'b0;
`endif
      if (cmd) begin
         // a command byte always wins, even mid-packet, and never pops
         if (hit) begin
            sb_rdata_d = status_byte(~bus.fifo_empty, underrun_q);
            state_d    = ST_STAT;
`ifdef PKT_SPI_READ_PACK_EN
            packed_d   = bus.sb_addr[0];
            pad_b_d    = 1'b0;
`endif
         end else begin
            sb_rdata_d = PAD_BYTE;
            state_d    = ST_IDLE;
         end
      end else begin
         case (state_q)
            ST_IDLE, ST_EOP: begin
               if (dat) sb_rdata_d = PAD_BYTE;
            end
            ST_STAT: begin
               if (dat) begin
                  underrun_d = 1'b0;
`ifdef PKT_SPI_READ_PACK_EN
                  if (packed_q) fetch_r   = 1'b1;
                  else          fetch_raw = 1'b1;
`else
                  fetch_raw = 1'b1;
`endif
               end
            end
            ST_RAW: begin
               if (dat) fetch_raw = 1'b1;
            end
`ifdef PKT_SPI_READ_PACK_EN
            ST_PK_R: begin
               if (dat) fetch_r = 1'b1;
            end
            ST_PK_G: begin
               fetch_g = 1'b1;
            end
            ST_PK_B: begin
               if (dat) fetch_b = 1'b1;
            end
`endif
            default: begin
               state_d = ST_IDLE;
            end
         endcase

         // the status-exit fetch happens in STAT, so an empty FIFO there
         // does not count as an underrun
         if (fetch_raw) begin
            if (!bus.fifo_empty) begin
               sb_rdata_d = bus.fifo_data;
               pop        = 1'b1;
               state_d    = bus.fifo_last ? ST_EOP : ST_RAW;
            end else begin
               sb_rdata_d = PAD_BYTE;
               state_d    = ST_RAW;
               if (state_q != ST_STAT) underrun_d = 1'b1;
            end
         end

`ifdef PKT_SPI_READ_PACK_EN
         if (fetch_r) begin
            if (!bus.fifo_empty) begin
               pop   = 1'b1;
               cap_r = 1'b1;
               if (bus.fifo_last) begin
                  sb_rdata_d = {bus.fifo_data[7:3], 3'b000};
                  state_d    = ST_EOP;
               end else begin
                  state_d    = ST_PK_G;
               end
            end else begin
               sb_rdata_d = PAD_BYTE;
               state_d    = ST_PK_R;
               if (state_q != ST_STAT) underrun_d = 1'b1;
            end
         end

         if (fetch_g) begin
            cap_g      = 1'b1;
            sb_rdata_d = rg_byte;
            state_d    = ST_PK_B;
            if (!bus.fifo_empty) begin
               pop     = 1'b1;
               pad_b_d = bus.fifo_last;
            end else begin
               underrun_d = 1'b1;
               pad_b_d    = 1'b0;
            end
         end

         // packet ended on G: emit {G[4:2],00000} without popping
         if (fetch_b) begin
            sb_rdata_d = gb_byte;
            if (pad_b_q) begin
               pad_b_d = 1'b0;
               state_d = ST_EOP;
            end else if (!bus.fifo_empty) begin
               pop     = 1'b1;
               state_d = bus.fifo_last ? ST_EOP : ST_PK_R;
            end else begin
               underrun_d = 1'b1;
               state_d    = ST_PK_R;
            end
         end
`endif
      end
   end

   // FSM, output byte and sticky underrun registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sb_rdata_q <= PAD_BYTE;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sb_rdata_q <= sb_rdata_d;
         underrun_q <= underrun_d;
      end
   end

`ifdef PKT_SPI_READ_PACK_EN
   // packed-mode select and pending-pad flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         packed_q <= 1'b0;
         pad_b_q  <= 1'b0;
      end else begin
         packed_q <= packed_d;
         pad_b_q  <= pad_b_d;
      end
   end
`endif

   assign bus.sb_rdata  = sb_rdata_q;
   assign bus.fifo_rden = pop;

endmodule
